// File: rtl/pipelined_barrel_shifter.sv
// ============================================================================
// pipelined_barrel_shifter
//
// Fully pipelined multifunction barrel shifter. It rotates or shifts a
// WIDTH-bit word by 0..WIDTH-1 positions. There is one log2 stage per
// pipeline register, so a new word can be accepted every clock. Stage i
// shifts by 2^i when bit i of the shift amount is set. The pipeline has a
// valid/ready stream handshake on both sides.
//
// Operations (in_op):
//   000 ROL   rotate left
//   001 ROR   rotate right
//   010 SLL   logical shift left, zero fill
//   011 SRL   logical shift right, zero fill
//   100 SRA   arithmetic shift right, filled with the operand's MSB
//   101..111  pass-through
//
// Ports:
//   clk        in   1      system clock, rising edge
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      input word valid
//   in_ready   out  1      block can accept input this cycle
//   in_data    in   WIDTH  operand
//   in_amt     in   LOG2W  shift/rotate amount
//   in_op      in   3      operation select
//   out_valid  out  1      result valid (registered)
//   out_ready  in   1      consumer accepts result this cycle
//   out_data   out  WIDTH  result (registered)
//
// Latency is LOG2W cycles. All stages advance together whenever the output
// register is empty or being drained. Bubbles are kept and never compressed,
// so ordering is preserved trivially.
// ============================================================================
module pipelined_barrel_shifter #(
    parameter int  WIDTH = 16,
    localparam int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LOG2W-1:0] in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [2:0] {
        OP_ROL = 3'b000,
        OP_ROR = 3'b001,
        OP_SLL = 3'b010,
        OP_SRL = 3'b011,
        OP_SRA = 3'b100
    } op_e;

    // Registered state of every stage.
    logic [WIDTH-1:0] data_q  [LOG2W];
    logic [LOG2W-1:0] amt_q   [LOG2W];
    logic [2:0]       op_q    [LOG2W];
    logic             sign_q  [LOG2W];
    logic             valid_q [LOG2W];

    // Stage inputs: stage 0 takes the input port, and stage i takes stage i-1.
    logic [WIDTH-1:0] src_data  [LOG2W];
    logic [LOG2W-1:0] src_amt   [LOG2W];
    logic [2:0]       src_op    [LOG2W];
    logic             src_sign  [LOG2W];
    logic             src_valid [LOG2W];

    // Next-state data for each stage register.
    logic [WIDTH-1:0] data_d [LOG2W];

    // Single global stall: the whole pipe moves iff the output slot frees up.
    logic advance;
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[LOG2W-1];
    assign out_data  = data_q[LOG2W-1];

    for (genvar i = 0; i < LOG2W; i++) begin : g_stage
        localparam int SH = 1 << i;

        logic [WIDTH-1:0] shifted;

        if (i == 0) begin : g_src_port
            assign src_data[i]  = in_data;
            assign src_amt[i]   = in_amt;
            assign src_op[i]    = in_op;
            // The SRA fill bit is sampled once from the operand. Partially
            // shifted data is not a valid source for the fill bit.
            assign src_sign[i]  = in_data[WIDTH-1];
            assign src_valid[i] = in_valid;
        end else begin : g_src_prev
            assign src_data[i]  = data_q[i-1];
            assign src_amt[i]   = amt_q[i-1];
            assign src_op[i]    = op_q[i-1];
            assign src_sign[i]  = sign_q[i-1];
            assign src_valid[i] = valid_q[i-1];
        end

        // Fixed-distance shift by 2^i. All part-selects are constant.
        always_comb begin
            // NOTE: a default assignment ahead of the case keeps this purely
            // combinational; any path that left 'shifted' unassigned would
            // infer a latch.
            shifted = src_data[i];
            case (src_op[i])
                OP_ROL:  shifted = {src_data[i][WIDTH-1-SH:0], src_data[i][WIDTH-1:WIDTH-SH]};
                OP_ROR:  shifted = {src_data[i][SH-1:0], src_data[i][WIDTH-1:SH]};
                OP_SLL:  shifted = {src_data[i][WIDTH-1-SH:0], {SH{1'b0}}};
                OP_SRL:  shifted = {{SH{1'b0}}, src_data[i][WIDTH-1:SH]};
                OP_SRA:  shifted = {{SH{src_sign[i]}}, src_data[i][WIDTH-1:SH]};
                default: shifted = src_data[i];
            endcase
        end

        // 2:1 select: apply this stage's shift only when its amount bit is set.
        assign data_d[i] = src_amt[i][i] ? shifted : src_data[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the data/amount/op registers are reset as well as the
            // valid bits. This makes out_data read zero during reset and keeps
            // the pipe free of X after power-up.
            for (int i = 0; i < LOG2W; i++) begin
                data_q[i]  <= '0;
                amt_q[i]   <= '0;
                op_q[i]    <= '0;
                sign_q[i]  <= 1'b0;
                valid_q[i] <= 1'b0;
            end
        end else if (advance) begin
            // NOTE: every stage reads its predecessor's old value on this
            // edge. Non-blocking assignment is what makes the words move one
            // stage per clock and not fall through the whole pipe at once.
            for (int i = 0; i < LOG2W; i++) begin
                data_q[i]  <= data_d[i];
                amt_q[i]   <= src_amt[i];
                op_q[i]    <= src_op[i];
                sign_q[i]  <= src_sign[i];
                valid_q[i] <= src_valid[i];
            end
        end
    end

    // Nothing reads the control fields of the final stage. Synthesis prunes them.
    logic unused_tail;
    assign unused_tail = ^{amt_q[LOG2W-1], op_q[LOG2W-1], sign_q[LOG2W-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// ============================================================================
// tb_pipelined_barrel_shifter
//
// Self-checking bench for pipelined_barrel_shifter at WIDTH=16. Stimulus
// tasks push the expected result onto a scoreboard queue when a word is
// accepted. A negedge monitor pops and compares each consumed result.
// ============================================================================
module tb_pipelined_barrel_shifter;

    localparam int W  = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [LW-1:0] in_amt;
    logic [2:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;

    logic [W-1:0] exp_q [$];
    logic [W-1:0] mon_exp;
    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [LW-1:0] a;
        logic [2:0]    op;
        logic [W-1:0]  e;
    } vec_t;

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Reference model, written independently of the stage structure.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [LW-1:0] a,
                                           input logic [2:0] op);
        logic [2*W-1:0] t;
        logic [W-1:0]   r;
        case (op)
            3'b000: begin t = {d, d} << a; r = t[2*W-1:W]; end
            3'b001: begin t = {d, d} >> a; r = t[W-1:0]; end
            3'b010: r = d << a;
            3'b011: r = d >> a;
            3'b100: r = $signed(d) >>> a;
            default: r = d;
        endcase
        return r;
    endfunction

    // Scoreboard monitor. out_ready only changes just after posedge, so the
    // value sampled here is the one used at the next consuming edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_unexpected: got %h with no word outstanding", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp)
                    $display("FAIL scoreboard_data: got %h expected %h", out_data, mon_exp);
                else
                    n_pass++;
            end
        end
    end

    // Present a word and hold it until it is accepted. The expected result is
    // pushed on the accepting edge. Returns 1 time unit after that edge.
    task automatic send(input logic [W-1:0] d, input logic [LW-1:0] a,
                        input logic [2:0] op, input logic [W-1:0] e);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_op    = op;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                exp_q.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_total++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        n_total++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
        else
            n_pass++;
    endtask

    // Send one word into an empty pipe with out_ready=1. out_valid must be low
    // on the accept cycle and the two cycles after it, and high on the fourth.
    task automatic check_latency(input logic [W-1:0] d, input logic [LW-1:0] a,
                                 input logic [2:0] op, input logic [W-1:0] e,
                                 input string name);
        logic req;
        send(d, a, op, e);
        idle();
        for (int c = 0; c < LW; c++) begin
            @(negedge clk);
            req = (c == LW - 1);
            n_total++;
            if (out_valid !== req)
                $display("FAIL %s_latency_c%0d: out_valid %b required %b", name, c + 1, out_valid, req);
            else
                n_pass++;
        end
        drain(name);
    endtask

    task automatic test_reset();
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = '0;
        out_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid);
        else n_pass++;
        n_total++;
        if (out_data !== '0) $display("FAIL reset_out_data: got %h required 0000", out_data);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_latency();
        check_latency(16'h8001, 4'd1, 3'b000, 16'h0003, "rol_8001");
    endtask

    task automatic test_op_sweep();
        vec_t v [$];
        v.push_back('{16'h8000, 4'd15, 3'b001, 16'h0001});
        v.push_back('{16'h8000, 4'd15, 3'b011, 16'h0001});
        v.push_back('{16'h8000, 4'd15, 3'b100, 16'hFFFF});
        v.push_back('{16'h8000, 4'd15, 3'b000, 16'h4000});
        v.push_back('{16'h8000, 4'd15, 3'b010, 16'h0000});
        v.push_back('{16'h0001, 4'd15, 3'b010, 16'h8000});
        v.push_back('{16'h7FFF, 4'd15, 3'b100, 16'h0000});
        v.push_back('{16'h4000, 4'd3,  3'b100, 16'h0800});
        v.push_back('{16'hF0F0, 4'd4,  3'b001, 16'h0F0F});
        v.push_back('{16'hFFFF, 4'd4,  3'b010, 16'hFFF0});
        v.push_back('{16'h1234, 4'd7,  3'b111, 16'h1234});
        v.push_back('{16'h1234, 4'd3,  3'b101, 16'h1234});
        v.push_back('{16'h1234, 4'd3,  3'b110, 16'h1234});
        for (int op = 0; op < 8; op++)
            v.push_back('{16'hA5C3, 4'd0, 3'(op), 16'hA5C3});
        foreach (v[k]) send(v[k].d, v[k].a, v[k].op, v[k].e);
        idle();
        drain("op_sweep");
    endtask

    task automatic test_back_to_back();
        fork
            begin
                logic [W-1:0] one;
                one = 16'h0001;
                for (int a = 0; a < 16; a++) send(one, 4'(a), 3'b000, one << a);
                idle();
            end
            begin
                bit seen = 1'b0;
                for (int t = 0; t < 40 && !seen; t++) begin
                    @(negedge clk);
                    if (out_valid === 1'b1) seen = 1'b1;
                end
                n_total++;
                if (!seen) $display("FAIL b2b_first_valid: out_valid never rose, required 1");
                else begin
                    n_pass++;
                    for (int k = 1; k < 16; k++) begin
                        @(negedge clk);
                        n_total++;
                        if (out_valid !== 1'b1)
                            $display("FAIL b2b_consecutive_%0d: out_valid %b required 1", k, out_valid);
                        else n_pass++;
                    end
                end
            end
        join
        drain("b2b");
    endtask

    task automatic test_backpressure();
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    logic [W-1:0] d;
                    d = 16'h1357 + 16'(k * 16'h0111);
                    send(d, 4'(k + 1), 3'(k % 5), model(d, 4'(k + 1), 3'(k % 5)));
                end
                idle();
            end
            begin
                bit seen = 1'b0;
                logic [W-1:0] held;
                for (int t = 0; t < 40 && !seen; t++) begin
                    @(negedge clk);
                    if (out_valid === 1'b1) seen = 1'b1;
                end
                if (!seen) begin
                    n_total++;
                    $display("FAIL bp_first_valid: out_valid never rose, required 1");
                end
                @(posedge clk); #1;
                @(posedge clk); #1;
                out_ready = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    if (k == 0) held = out_data;
                    n_total++;
                    if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d: got %b required 0", k, in_ready);
                    else n_pass++;
                    n_total++;
                    if (out_valid !== 1'b1) $display("FAIL bp_out_valid_%0d: got %b required 1", k, out_valid);
                    else n_pass++;
                    n_total++;
                    if (out_data !== held) $display("FAIL bp_stable_%0d: got %h required %h", k, out_data, held);
                    else n_pass++;
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain("backpressure");
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    logic [W-1:0]  d;
                    logic [LW-1:0] a;
                    logic [2:0]    op;
                    d  = 16'($urandom);
                    a  = 4'($urandom_range(0, 15));
                    op = 3'($urandom_range(0, 7));
                    send(d, a, op, model(d, a, op));
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(posedge clk); #1;
                    end
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("random");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(16'h1111, 4'd1, 3'b000, 16'h2222);
        send(16'h2222, 4'd2, 3'b001, 16'h8888);
        send(16'h3333, 4'd3, 3'b011, 16'h0666);
        idle();
        @(posedge clk); #1;
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL rst_mid_loaded: out_valid %b required 1", out_valid);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b required 0", out_valid);
        else n_pass++;
        n_total++;
        if (out_data !== '0) $display("FAIL rst_mid_out_data: got %h required 0000", out_data);
        else n_pass++;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL rst_mid_flushed_%0d: out_valid %b required 0", k, out_valid);
            else n_pass++;
        end
        @(posedge clk); #1;
        check_latency(16'h0001, 4'd4, 3'b001, 16'h1000, "rst_mid_new");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_op_sweep();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, fully pipelined multifunction barrel shifter.
- Supports rotate left/right, logical shift left/right and arithmetic shift right on a WIDTH-bit word.
- One log2 stage per pipeline register, with a valid/ready stream handshake on both sides.
- Sits between a stream producer (ALU operand path, test pattern source) and any ready-capable consumer; sustains one result per clock.

Parameters:
WIDTH, 16, data width in bits; must be a power of two, 2..64
LOG2W, $clog2(WIDTH), shift amount width and pipeline depth; derived, not overridden

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  block can accept input this cycle
in_data  in  WIDTH  operand
in_amt  in  LOG2W  shift/rotate amount, 0..WIDTH-1
in_op  in  3  operation select (see Behaviour)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result this cycle
out_data  out  WIDTH  result

Behaviour:
- Op encoding:
  - 000 ROL
  - 001 ROR
  - 010 SLL (zero fill)
  - 011 SRL (zero fill)
  - 100 SRA (fill with in_data[WIDTH-1])
  - 101/110/111 pass-through (out_data = in_data).
- Reset (reset_n low, asynchronous): all stage valid bits 0; all stage data, amount and op registers 0. Hence out_valid=0 and out_data=0. Takes effect immediately, independent of clk.
- Reset mid-operation: every in-flight word is discarded and never emerges. After reset_n deasserts, first acceptance is possible on the next rising edge.
- Pipeline structure:
  - LOG2W registered stages. Stage i applies a shift of 2^i when amt bit i is set.
  - Each stage carries data, remaining amt bits, op and a valid bit.
  - The sign bit for SRA is captured at stage 0 from in_data and carried down the pipe. It is not re-read from shifted data.
- Stall rule: advance = ~out_valid | out_ready.
  - in_ready = advance, combinational; no dependency on in_valid.
  - When advance=1, all stages shift one step on the clock edge. When advance=0, all stages hold.
  - Bubbles are not compressed.
- Acceptance: an input is accepted on an edge where in_valid & in_ready.
  - If in_valid=0 while advance=1, a bubble (valid=0) enters stage 0.
- Output handshake: a result is consumed on an edge where out_valid & out_ready.
  - out_data/out_valid are register outputs. They stay stable while out_valid=1 and out_ready=0.
- Latency: a word accepted on edge k is on out_data with out_valid=1 after edge k+LOG2W-1, i.e. LOG2W cycles with no stalls. For WIDTH=16: 4 cycles.
- Throughput: 1 word/cycle while out_ready=1. Ordering is strictly preserved; no loss or duplication under any out_ready pattern.
- Simultaneous consume and accept on the same edge is legal and required at full rate.
- Boundary conditions:
  - amt=0 returns in_data unchanged for all ops.
  - amt=WIDTH-1:
    - ROL/ROR = rotate by WIDTH-1.
    - SLL leaves only bit 0 → bit WIDTH-1.
    - SRL leaves only the MSB → bit 0.
    - SRA = all sign bits.
- Uses no multipliers and no variable-index part-selects. Built from per-stage 2:1 mux selection only.

Test Plan:
- WIDTH=16, out_ready=1. ROL 0x8001 amt=1 → 0x0003. out_valid asserts exactly 4 cycles after accept with no earlier spurious valid.
- Op sweep on 0x8000, amt=15:
  - ROR → 0x0001
  - SRL → 0x0001
  - SRA → 0xFFFF
  - ROL → 0x4000
  - SLL → 0x0000
- SLL 0xFFFF amt=4 → 0xFFF0. Op 111 on 0x1234 amt=7 → 0x1234. amt=0 on all ops with 0xA5C3 → 0xA5C3.
- Back-to-back stream of 16 ROL words (0x0001, amt=0..15), one per cycle → 0x0001,0x0002,…,0x8000 in order on consecutive cycles.
- Backpressure: feed 8 words, hold out_ready=0 for 6 cycles mid-stream.
  - in_ready drops the cycle the output holds.
  - out_data is stable while stalled.
  - All 8 results arrive in order with no loss or duplication.
- Reset: assert reset_n=0 asynchronously with 3 words in flight.
  - out_valid=0 and out_data=0 immediately.
  - None of the 3 words emerges after release.
  - A new word accepted after release returns correctly after 4 cycles.
